// File: rtl/fir_pkg.sv
// Shared types for the FIR engine scheduler: FSM state encoding and channel-index sizing.
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        WRITE = 2'd2
    } sched_state_t;

    localparam int DATA_W = 32;

    function automatic int ch_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/fir_rr_arb.sv
// Combinational round-robin arbiter: first requester after 'last', wrapping modulo NUM_CH.
module fir_rr_arb
    import fir_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int CH_W   = ch_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   last,
    output logic              gnt_valid,
    output logic [CH_W-1:0]   gnt_idx
);

    logic [CH_W-1:0] idx;

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        idx       = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = CH_W'((int'(last) + i) % NUM_CH);
            if (!gnt_valid && req[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = idx;
            end
        end
    end

endmodule

// File: rtl/fir_sched.sv
// Time-shares one complex FIR engine among NUM_CH channels, one outstanding sample at a time,
// with a watchdog that abandons a transaction when the engine never answers.
module fir_sched
    import fir_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int TIMEOUT = 64,
    localparam int CH_W   = ch_width(NUM_CH)
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic [NUM_CH-1:0]              ch_en,
    input  logic [NUM_CH-1:0][DATA_W-1:0]  ch_i_in,
    input  logic [NUM_CH-1:0][DATA_W-1:0]  ch_q_in,
    input  logic [NUM_CH-1:0]              ch_empty,
    output logic [NUM_CH-1:0]              ch_rd_en,
    input  logic [NUM_CH-1:0]              ch_full,
    output logic [NUM_CH-1:0]              ch_wr_en,
    output logic [DATA_W-1:0]              y_real_out,
    output logic [DATA_W-1:0]              y_imag_out,
    output logic [CH_W-1:0]                eng_ch,
    output logic                           eng_in_valid,
    output logic [DATA_W-1:0]              eng_i,
    output logic [DATA_W-1:0]              eng_q,
    input  logic                           eng_out_valid,
    input  logic [DATA_W-1:0]              eng_real,
    input  logic [DATA_W-1:0]              eng_imag,
    output logic                           busy,
    output logic                           err_timeout,
    input  logic                           err_clr
);

    localparam int WD_W = $clog2(TIMEOUT) + 1;

    sched_state_t        state;
    logic [CH_W-1:0]     cur;
    logic [CH_W-1:0]     last_grant;
    logic [WD_W-1:0]     wd;
    logic [WD_W-1:0]     wd_next;
    logic [DATA_W-1:0]   res_real;
    logic [DATA_W-1:0]   res_imag;
    logic [NUM_CH-1:0]   eligible;
    logic                gnt_valid;
    logic [CH_W-1:0]     gnt_idx;
    logic                grant;
    logic                timeout_hit;

    assign eligible    = ch_en & ~ch_empty & ~ch_full;
    assign grant       = (state == IDLE) && gnt_valid;
    assign wd_next     = wd + 1'b1;
    assign timeout_hit = (state == WAIT) && !eng_out_valid && (wd_next == WD_W'(TIMEOUT - 1));
    assign busy        = (state != IDLE);
    assign y_real_out  = res_real;
    assign y_imag_out  = res_imag;

    fir_rr_arb #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_arb (
        .req       (eligible),
        .last      (last_grant),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    // The issue path is combinational so a pop and the engine strobe land in the grant cycle.
    always_comb begin
        ch_rd_en     = '0;
        ch_wr_en     = '0;
        eng_in_valid = 1'b0;
        eng_i        = '0;
        eng_q        = '0;
        eng_ch       = cur;
        if (grant) begin
            ch_rd_en[gnt_idx] = 1'b1;
            eng_in_valid      = 1'b1;
            eng_i             = ch_i_in[gnt_idx];
            eng_q             = ch_q_in[gnt_idx];
            eng_ch            = gnt_idx;
        end
        if ((state == WRITE) && !ch_full[cur]) begin
            ch_wr_en[cur] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cur        <= '0;
            last_grant <= CH_W'(NUM_CH - 1);
            wd         <= '0;
            res_real   <= '0;
            res_imag   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_valid) begin
                        cur        <= gnt_idx;
                        last_grant <= gnt_idx;
                        wd         <= '0;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    if (eng_out_valid) begin
                        res_real <= eng_real;
                        res_imag <= eng_imag;
                        state    <= WRITE;
                    end else begin
                        wd <= wd_next;
                        if (timeout_hit) begin
                            state <= IDLE;
                        end
                    end
                end
                WRITE: begin
                    if (!ch_full[cur]) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A timeout in the same cycle as a clear request keeps the flag set.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_timeout <= 1'b0;
        end else if (timeout_hit) begin
            err_timeout <= 1'b1;
        end else if (err_clr) begin
            err_timeout <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fir_sched.sv
// Scoreboard bench for fir_sched: FIFO and x2 engine models drive the main instance,
// a second instance with a short watchdog checks the timeout path.
module tb_fir_sched;

    localparam int NUM_CH = 2;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic                         reset_n;
    logic [NUM_CH-1:0]            ch_en;
    logic [NUM_CH-1:0][31:0]      ch_i_in;
    logic [NUM_CH-1:0][31:0]      ch_q_in;
    logic [NUM_CH-1:0]            ch_empty;
    logic [NUM_CH-1:0]            ch_rd_en;
    logic [NUM_CH-1:0]            ch_full;
    logic [NUM_CH-1:0]            ch_wr_en;
    logic [31:0]                  y_real_out;
    logic [31:0]                  y_imag_out;
    logic [0:0]                   eng_ch;
    logic                         eng_in_valid;
    logic [31:0]                  eng_i;
    logic [31:0]                  eng_q;
    logic                         eng_out_valid;
    logic [31:0]                  eng_real;
    logic [31:0]                  eng_imag;
    logic                         busy;
    logic                         err_timeout;
    logic                         err_clr;

    logic                         w_reset_n;
    logic [NUM_CH-1:0]            w_ch_en;
    logic [NUM_CH-1:0][31:0]      w_ch_i_in;
    logic [NUM_CH-1:0][31:0]      w_ch_q_in;
    logic [NUM_CH-1:0]            w_ch_empty;
    logic [NUM_CH-1:0]            w_ch_rd_en;
    logic [NUM_CH-1:0]            w_ch_full;
    logic [NUM_CH-1:0]            w_ch_wr_en;
    logic [31:0]                  w_y_real_out;
    logic [31:0]                  w_y_imag_out;
    logic [0:0]                   w_eng_ch;
    logic                         w_eng_in_valid;
    logic [31:0]                  w_eng_i;
    logic [31:0]                  w_eng_q;
    logic                         w_eng_out_valid;
    logic [31:0]                  w_eng_real;
    logic [31:0]                  w_eng_imag;
    logic                         w_busy;
    logic                         w_err_timeout;
    logic                         w_err_clr;

    fir_sched #(.NUM_CH(NUM_CH), .TIMEOUT(64)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .ch_en         (ch_en),
        .ch_i_in       (ch_i_in),
        .ch_q_in       (ch_q_in),
        .ch_empty      (ch_empty),
        .ch_rd_en      (ch_rd_en),
        .ch_full       (ch_full),
        .ch_wr_en      (ch_wr_en),
        .y_real_out    (y_real_out),
        .y_imag_out    (y_imag_out),
        .eng_ch        (eng_ch),
        .eng_in_valid  (eng_in_valid),
        .eng_i         (eng_i),
        .eng_q         (eng_q),
        .eng_out_valid (eng_out_valid),
        .eng_real      (eng_real),
        .eng_imag      (eng_imag),
        .busy          (busy),
        .err_timeout   (err_timeout),
        .err_clr       (err_clr)
    );

    fir_sched #(.NUM_CH(NUM_CH), .TIMEOUT(8)) wd_dut (
        .clock         (clock),
        .reset_n       (w_reset_n),
        .ch_en         (w_ch_en),
        .ch_i_in       (w_ch_i_in),
        .ch_q_in       (w_ch_q_in),
        .ch_empty      (w_ch_empty),
        .ch_rd_en      (w_ch_rd_en),
        .ch_full       (w_ch_full),
        .ch_wr_en      (w_ch_wr_en),
        .y_real_out    (w_y_real_out),
        .y_imag_out    (w_y_imag_out),
        .eng_ch        (w_eng_ch),
        .eng_in_valid  (w_eng_in_valid),
        .eng_i         (w_eng_i),
        .eng_q         (w_eng_q),
        .eng_out_valid (w_eng_out_valid),
        .eng_real      (w_eng_real),
        .eng_imag      (w_eng_imag),
        .busy          (w_busy),
        .err_timeout   (w_err_timeout),
        .err_clr       (w_err_clr)
    );

    logic [63:0] in_q[NUM_CH][$];
    logic [63:0] exp_q[NUM_CH][$];
    int          eng_due[$];
    logic [63:0] eng_res[$];
    int          grant_log[$];
    int          issue_log[$];
    int          rd_cnt[NUM_CH];
    int          wr_cnt;
    int          last_wr_cyc;
    int          cyc;
    int          lat;
    bit          spur;
    int          num_checks;
    int          num_fails;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic refresh();
        for (int c = 0; c < NUM_CH; c++) begin
            ch_empty[c] = (in_q[c].size() == 0);
            ch_i_in[c]  = (in_q[c].size() == 0) ? 32'h0 : in_q[c][0][63:32];
            ch_q_in[c]  = (in_q[c].size() == 0) ? 32'h0 : in_q[c][0][31:0];
        end
    endtask

    task automatic applyStimulus(input int c, input logic [31:0] i, input logic [31:0] q);
        in_q[c].push_back({i, q});
        exp_q[c].push_back({i << 1, q << 1});
        refresh();
    endtask

    function automatic bit allEmpty();
        bit e;
        e = (eng_due.size() == 0);
        for (int c = 0; c < NUM_CH; c++) begin
            if (in_q[c].size() != 0 || exp_q[c].size() != 0) e = 1'b0;
        end
        return e;
    endfunction

    // One cycle: observe at the falling edge, then update FIFO and engine models after the rising edge.
    task automatic step();
        logic [NUM_CH-1:0] rd;
        logic [NUM_CH-1:0] wr;
        logic [NUM_CH-1:0] full_s;
        logic [NUM_CH-1:0] oh;
        logic              eiv;
        int                ech;
        int                wc;
        logic [63:0]       edata;
        logic [63:0]       ydata;
        @(negedge clock);
        rd     = ch_rd_en;
        wr     = ch_wr_en;
        full_s = ch_full;
        eiv    = eng_in_valid;
        ech    = int'(eng_ch);
        edata  = {eng_i, eng_q};
        ydata  = {y_real_out, y_imag_out};
        if (eiv || rd != 0) begin
            oh      = '0;
            oh[ech] = 1'b1;
            checkOutput("issue_strobes", {rd, eiv}, {oh, 1'b1});
            checkOutput("issue_not_empty", in_q[ech].size() > 0, 1);
            if (in_q[ech].size() > 0) checkOutput("issue_data", edata, in_q[ech][0]);
            grant_log.push_back(ech);
            issue_log.push_back(cyc);
            rd_cnt[ech]++;
            eng_due.push_back(cyc + lat);
            eng_res.push_back({edata[63:32] << 1, edata[31:0] << 1});
        end
        if (wr != 0) begin
            wc = 0;
            for (int c = 0; c < NUM_CH; c++) if (wr[c]) wc = c;
            checkOutput("wr_onehot", $countones(wr), 1);
            checkOutput("wr_not_full", wr & full_s, 0);
            if (exp_q[wc].size() == 0) checkOutput("wr_unexpected", wr, 0);
            else checkOutput($sformatf("wr_data_ch%0d", wc), ydata, exp_q[wc].pop_front());
            wr_cnt++;
            last_wr_cyc = cyc;
        end
        @(posedge clock);
        #1;
        if (rd != 0 && in_q[ech].size() > 0) void'(in_q[ech].pop_front());
        cyc++;
        eng_out_valid = 1'b0;
        eng_real      = '0;
        eng_imag      = '0;
        if (eng_due.size() > 0 && eng_due[0] == cyc) begin
            eng_out_valid = 1'b1;
            {eng_real, eng_imag} = eng_res.pop_front();
            void'(eng_due.pop_front());
        end else if (spur) begin
            eng_out_valid = 1'b1;
            eng_real      = 32'hDEADBEEF;
            eng_imag      = 32'hDEADBEEF;
        end
        spur = 1'b0;
        refresh();
    endtask

    task automatic waitDrain(input string tag, input int max_cycles);
        bit done;
        done = 1'b0;
        for (int n = 0; n < max_cycles && !done; n++) begin
            step();
            done = allEmpty() && (busy == 1'b0);
        end
        checkOutput({tag, "_drained"}, done, 1);
    endtask

    task automatic waitIssue(input string tag, input int count, input int max_cycles);
        for (int n = 0; n < max_cycles && issue_log.size() < count; n++) step();
        checkOutput({tag, "_issued"}, issue_log.size() >= count, 1);
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        #1;
        for (int c = 0; c < NUM_CH; c++) begin
            in_q[c].delete();
            exp_q[c].delete();
        end
        eng_due.delete();
        eng_res.delete();
        grant_log.delete();
        issue_log.delete();
        rd_cnt        = '{default: 0};
        wr_cnt        = 0;
        last_wr_cyc   = 0;
        eng_out_valid = 1'b0;
        eng_real      = '0;
        eng_imag      = '0;
        spur          = 1'b0;
        ch_full       = '0;
        ch_en         = '1;
        refresh();
        @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    function automatic int logAt(input int q[$], input int k);
        return (q.size() > k) ? q[k] : -1;
    endfunction

    initial begin
        logic [NUM_CH-1:0] wr_seen;
        num_checks = 0;
        num_fails  = 0;
        cyc        = 0;
        lat        = 1;
        reset_n    = 1'b1;
        w_reset_n  = 1'b1;
        err_clr    = 1'b0;
        ch_full    = '0;
        ch_en      = '1;
        spur       = 1'b0;
        eng_out_valid = 1'b0;
        eng_real   = '0;
        eng_imag   = '0;
        refresh();
        w_ch_en         = 2'b01;
        w_ch_i_in       = '0;
        w_ch_q_in       = '0;
        w_ch_empty      = 2'b11;
        w_ch_full       = '0;
        w_eng_out_valid = 1'b0;
        w_eng_real      = '0;
        w_eng_imag      = '0;
        w_err_clr       = 1'b0;
        #1;
        reset_n   = 1'b0;
        w_reset_n = 1'b0;
        #2;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_strobes", {ch_rd_en, ch_wr_en, eng_in_valid}, 0);
        checkOutput("rst_eng_data", {eng_i, eng_q}, 0);
        checkOutput("rst_eng_ch", eng_ch, 0);
        checkOutput("rst_y", {y_real_out, y_imag_out}, 0);
        checkOutput("rst_err", err_timeout, 0);
        @(posedge clock);
        #1;
        reset_n   = 1'b1;
        w_reset_n = 1'b1;

        $display("[TB] single channel, latency 20");
        doReset();
        lat = 20;
        applyStimulus(0, 32'h00000005, 32'hFFFFFFFB);
        waitDrain("single", 60);
        checkOutput("single_rd_count", rd_cnt[0], 1);
        checkOutput("single_wr_count", wr_cnt, 1);
        checkOutput("single_wr_latency", last_wr_cyc - logAt(issue_log, 0), 21);

        $display("[TB] fairness, latency 3");
        doReset();
        lat = 3;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 32'd100 + k, 32'd200 + k);
            applyStimulus(1, 32'd300 + k, 32'd400 + k);
        end
        waitDrain("fair", 100);
        for (int k = 0; k < 8; k++) begin
            checkOutput($sformatf("fair_grant%0d", k), logAt(grant_log, k), k % 2);
        end
        for (int k = 1; k < 8; k++) begin
            checkOutput($sformatf("fair_spacing%0d", k), logAt(issue_log, k) - logAt(issue_log, k - 1), 5);
        end

        $display("[TB] backpressure");
        doReset();
        lat     = 4;
        ch_full = 2'b10;
        applyStimulus(0, 32'h11110000, 32'h00002222);
        applyStimulus(1, 32'h00000007, 32'h00000008);
        waitIssue("bp_first", 1, 10);
        checkOutput("bp_first_grant", logAt(grant_log, 0), 0);
        ch_full = 2'b11;
        repeat (10) step();
        checkOutput("bp_hold_no_write", wr_cnt, 0);
        checkOutput("bp_hold_busy", busy, 1);
        checkOutput("bp_hold_y", {y_real_out, y_imag_out}, 64'h22220000_00004444);
        repeat (3) step();
        checkOutput("bp_hold_y_stable", {y_real_out, y_imag_out}, 64'h22220000_00004444);
        ch_full = 2'b00;
        waitDrain("bp", 60);
        checkOutput("bp_second_grant", logAt(grant_log, 1), 1);
        checkOutput("bp_wr_count", wr_cnt, 2);

        $display("[TB] spurious result and masked channel");
        doReset();
        lat   = 2;
        ch_en = 2'b10;
        spur  = 1'b1;
        repeat (4) step();
        checkOutput("spur_no_write", wr_cnt, 0);
        checkOutput("spur_y_unchanged", {y_real_out, y_imag_out}, 0);
        checkOutput("spur_idle", busy, 0);
        applyStimulus(0, 32'hCAFE0000, 32'h0000BEEF);
        applyStimulus(1, 32'h00000031, 32'h00000042);
        repeat (20) step();
        checkOutput("mask_ch0_rd", rd_cnt[0], 0);
        checkOutput("mask_ch1_rd", rd_cnt[1], 1);
        checkOutput("mask_wr_count", wr_cnt, 1);
        ch_en = 2'b11;
        waitDrain("mask", 30);
        checkOutput("unmask_ch0_rd", rd_cnt[0], 1);

        $display("[TB] reset during WAIT");
        doReset();
        lat = 20;
        applyStimulus(1, 32'hA5A5A5A5, 32'h5A5A5A5A);
        waitIssue("rst_mid", 1, 10);
        repeat (3) step();
        checkOutput("rst_mid_busy_before", busy, 1);
        checkOutput("rst_mid_eng_ch_before", eng_ch, 1);
        reset_n = 1'b0;
        #1;
        checkOutput("rst_mid_busy", busy, 0);
        checkOutput("rst_mid_eng_ch", eng_ch, 0);
        checkOutput("rst_mid_strobes", {ch_rd_en, ch_wr_en, eng_in_valid}, 0);
        checkOutput("rst_mid_eng_data", {eng_i, eng_q}, 0);
        checkOutput("rst_mid_y", {y_real_out, y_imag_out}, 0);
        doReset();
        lat = 2;
        applyStimulus(0, 32'h00000001, 32'h00000002);
        applyStimulus(1, 32'h00000003, 32'h00000004);
        waitDrain("rst_after", 40);
        checkOutput("rst_after_first_grant", logAt(grant_log, 0), 0);
        checkOutput("rst_after_wr_count", wr_cnt, 2);

        $display("[TB] watchdog, TIMEOUT 8");
        w_ch_i_in[0] = 32'h00001234;
        w_ch_q_in[0] = 32'h00005678;
        w_ch_empty   = 2'b10;
        @(negedge clock);
        checkOutput("wd_issue", {w_ch_rd_en, w_eng_in_valid}, 3'b011);
        @(posedge clock);
        #1;
        w_ch_empty = 2'b11;
        wr_seen    = '0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            wr_seen |= w_ch_wr_en;
            if (k == 7) begin
                checkOutput("wd_not_yet", w_err_timeout, 0);
                checkOutput("wd_still_waiting", w_busy, 1);
            end
            if (k == 8) begin
                checkOutput("wd_err_set", w_err_timeout, 1);
                checkOutput("wd_back_idle", w_busy, 0);
            end
        end
        checkOutput("wd_no_write", wr_seen, 0);
        @(posedge clock);
        #1;
        w_err_clr = 1'b1;
        @(negedge clock);
        checkOutput("wd_err_sticky", w_err_timeout, 1);
        @(posedge clock);
        #1;
        w_err_clr = 1'b0;
        @(negedge clock);
        checkOutput("wd_err_cleared", w_err_timeout, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule
